// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction sequencer:
// state encoding and the counter-width helper.
package serial_sub_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  // Ceiling log2, never less than 1 so a W=1 build still has a counter bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_sub_bit_cell.sv
// One-bit full subtractor: two half-subtract stages whose borrows are ORed.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  assign d1   = a ^ b;
  assign b1   = ~a & b;
  assign d    = d1 ^ bin;
  assign b2   = ~d1 & bin;
  assign bout = b1 | b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B sequencer, LSB first, one bit per clock.
// start/busy on the request side, result_valid/result_ready on the result side.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] diff,
  output logic         borrow_out,
  output logic         zero
);

  localparam int CW = clog2(W);

  state_t         state_reg;
  state_t         state_next;
  logic [W-1:0]   sh_a_reg;
  logic [W-1:0]   sh_b_reg;
  logic [W-1:0]   res_reg;
  logic [W-1:0]   res_shift;
  logic           bor_reg;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   diff_reg;
  logic           borrow_reg;
  logic           zero_reg;

  logic           load;
  logic           step;
  logic           finish;
  logic           cell_d;
  logic           cell_bout;

  sub_bit_cell u_cell (
    .a    (sh_a_reg[0]),
    .b    (sh_b_reg[0]),
    .bin  (bor_reg),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Result register after this step's bit enters at the MSB.
  generate
    if (W == 1) begin : g_res_w1
      assign res_shift = cell_d;
    end else begin : g_res_wn
      assign res_shift = {cell_d, res_reg[W-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (cnt_reg == CW'(W - 1)) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          if (start) begin
            load       = 1'b1;
            state_next = ST_RUN;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      sh_a_reg   <= '0;
      sh_b_reg   <= '0;
      res_reg    <= '0;
      bor_reg    <= 1'b0;
      cnt_reg    <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        sh_a_reg <= op_a;
        sh_b_reg <= op_b;
        bor_reg  <= 1'b0;
        cnt_reg  <= '0;
      end
      if (step) begin
        sh_a_reg <= sh_a_reg >> 1;
        sh_b_reg <= sh_b_reg >> 1;
        res_reg  <= res_shift;
        bor_reg  <= cell_bout;
        cnt_reg  <= cnt_reg + CW'(1);
      end
      // Visible outputs only move on the edge that enters DONE.
      if (finish) begin
        diff_reg   <= res_shift;
        borrow_reg <= cell_bout;
        zero_reg   <= (res_shift == '0);
      end
    end
  end

  assign busy         = (state_reg == ST_RUN);
  assign result_valid = (state_reg == ST_DONE);
  assign diff         = diff_reg;
  assign borrow_out   = borrow_reg;
  assign zero         = zero_reg;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: a W=8 instance for the main scenarios
// and a W=1 instance for the single-bit corner.
module tb_serial_sub_ctrl;

  typedef struct packed {
    logic [7:0] d;
    logic       b;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       result_ready = 1'b1;
  logic       busy;
  logic       result_valid;
  logic [7:0] diff;
  logic       borrow_out;
  logic       zero;

  logic       start1 = 1'b0;
  logic [0:0] op_a1 = '0;
  logic [0:0] op_b1 = '0;
  logic       ready1 = 1'b1;
  logic       busy1;
  logic       valid1;
  logic [0:0] diff1;
  logic       borrow1;
  logic       zero1;

  exp_t sb[$];
  exp_t sb1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .diff(diff), .borrow_out(borrow_out), .zero(zero)
  );

  serial_sub_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .busy(busy1), .result_valid(valid1), .result_ready(ready1),
    .diff(diff1), .borrow_out(borrow1), .zero(zero1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one edge and push the reference result.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    exp_t e;
    full = {1'b0, a} - {1'b0, b};
    e.d = full[7:0];
    e.b = full[8];
    e.z = (full[7:0] == 8'h00);
    sb.push_back(e);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (result_valid) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || diff !== 8'h00 ||
        borrow_out !== 1'b0 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b diff=%h borrow=%b zero=%b, want all 0",
               busy, result_valid, diff, borrow_out, zero);
    end
    $display("reset: busy=%b valid=%b diff=%h", busy, result_valid, diff);
  endtask

  task automatic test_basic(input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic ok;
    exp_t e;
    issue(a, b);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b after accept, want 1", busy);
    end
    wait_valid(lat, ok);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (!ok || lat != 8) begin
      errors++;
      $display("FAIL basic_latency %h-%h: got %0d (ok=%b), want 8", a, b, lat, ok);
    end
    checks++;
    if (diff !== e.d || borrow_out !== e.b || zero !== e.z || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result %h-%h: diff=%h borrow=%b zero=%b busy=%b, want %h %b %b 0",
               a, b, diff, borrow_out, zero, busy, e.d, e.b, e.z);
    end
    $display("sub %h-%h: diff=%h borrow=%b zero=%b lat=%0d", a, b, diff, borrow_out, zero, lat);
    tick();
  endtask

  task automatic test_hold();
    int lat;
    logic ok;
    exp_t e;
    result_ready = 1'b0;
    issue(8'hC3, 8'hC3);
    wait_valid(lat, ok);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (!ok || diff !== e.d || zero !== e.z || borrow_out !== e.b) begin
      errors++;
      $display("FAIL hold_result: diff=%h zero=%b borrow=%b ok=%b, want %h %b %b",
               diff, zero, borrow_out, ok, e.d, e.z, e.b);
    end
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      op_a  = 8'h77;
      op_b  = 8'h11;
      tick();
      checks++;
      if (result_valid !== 1'b1 || busy !== 1'b0 || diff !== e.d || zero !== e.z) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b busy=%b diff=%h zero=%b, want 1 0 %h %b",
                 i, result_valid, busy, diff, zero, e.d, e.z);
      end
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || diff !== e.d) begin
      errors++;
      $display("FAIL hold_release: valid=%b busy=%b diff=%h, want 0 0 %h",
               result_valid, busy, diff, e.d);
    end
    $display("hold C3-C3: diff=%h zero=%b held 5 cycles", diff, zero);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic ok;
    exp_t e;
    result_ready = 1'b0;
    issue(8'h30, 8'h10);
    wait_valid(lat, ok);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (!ok || diff !== e.d) begin
      errors++;
      $display("FAIL b2b_first: diff=%h ok=%b, want %h", diff, ok, e.d);
    end
    result_ready = 1'b1;
    issue(8'h09, 8'h04);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: valid=%b busy=%b, want 0 1", result_valid, busy);
    end
    // Toggle start with junk operands during RUN; must not disturb the result.
    lat = 0;
    ok  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      start = n[0];
      op_a  = 8'hFF;
      op_b  = 8'hAA;
      tick();
      if (result_valid) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
    start = 1'b0;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (!ok || lat != 8 || diff !== e.d || borrow_out !== e.b) begin
      errors++;
      $display("FAIL b2b_second: diff=%h borrow=%b lat=%0d ok=%b, want %h %b 8",
               diff, borrow_out, lat, ok, e.d, e.b);
    end
    $display("b2b 09-04: diff=%h lat=%0d", diff, lat);
    tick();
  endtask

  task automatic test_reset_mid_run();
    issue(8'h55, 8'h22);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    if (sb.size() > 0) void'(sb.pop_front());
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b valid=%b diff=%h borrow=%b, want 0 0 00 0",
               busy, result_valid, diff, borrow_out);
    end
    $display("reset mid-run: busy=%b valid=%b diff=%h", busy, result_valid, diff);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_basic(8'hFF, 8'h01);
  endtask

  task automatic test_w1();
    logic ok;
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      e.d = {7'b0, p[1] ^ p[0]};
      e.b = ~p[1] & p[0];
      e.z = ~(p[1] ^ p[0]);
      sb1.push_back(e);
      start1 = 1'b1;
      op_a1  = p[1];
      op_b1  = p[0];
      tick();
      start1 = 1'b0;
      checks++;
      if (busy1 !== 1'b1) begin
        errors++;
        $display("FAIL w1_busy %0d-%0d: busy=%b, want 1", p[1], p[0], busy1);
      end
      tick();
      ok = valid1;
      e = (sb1.size() > 0) ? sb1.pop_front() : '0;
      checks++;
      if (ok !== 1'b1 || diff1 !== e.d[0] || borrow1 !== e.b || zero1 !== e.z) begin
        errors++;
        $display("FAIL w1 %0d-%0d: valid=%b diff=%b borrow=%b zero=%b, want 1 %b %b %b",
                 p[1], p[0], ok, diff1, borrow1, zero1, e.d[0], e.b, e.z);
      end
      $display("w1 %0d-%0d: diff=%b borrow=%b", p[1], p[0], diff1, borrow1);
      tick();
    end
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_basic(8'h5A, 8'h23);
    test_basic(8'h10, 8'h20);
    test_basic(8'h00, 8'h01);
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_w1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
